// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Takes a framed byte stream (COUNT, N*4 data bytes MSB-first, CHK) over a
// valid/ready handshake, writes the assembled 32-bit words from address 0
// upward, checks an XOR checksum and stalls the CPU while a load runs.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W = 5,   // must be <= 7 so a COUNT byte can express 2**ADDR_W
  parameter int DATA_W = 32   // four bytes per word
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
  // byte_ready depends only on the current state, never on byte_valid, so the
  // source may hold a byte for any number of cycles without it being consumed.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam int              MAX_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q;
  logic [DATA_W-1:0]   buf_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          chk_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     words_q;
  logic [1:0]          idx_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                hold_q;

  logic                byte_accept;
  logic [ADDR_W:0]     words_d;
  logic                count_bad;

  // Handshake decode and next-value helpers shared by the FSM.
  always_comb begin
    byte_ready  = (state_q == S_COUNT) || (state_q == S_COLLECT) || (state_q == S_CHECK);
    byte_accept = byte_valid && byte_ready;
    words_d     = words_q + WORD_ONE;
    count_bad   = (byte_in == 8'd0) || (int'(byte_in) > MAX_WORDS);
  end

  // Load FSM: frame parsing, word assembly, sequential writes and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      addr_q  <= '0;
      chk_q   <= '0;
      count_q <= '0;
      words_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q <= S_COUNT;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            words_q <= '0;
            addr_q  <= '0;
            chk_q   <= '0;
            busy_q  <= 1'b1;
            hold_q  <= 1'b1;
          end
        end
        S_COUNT: begin
          if (byte_accept) begin
            if (count_bad) begin
              // Rejected frame length: hold stays asserted until a good load.
              state_q <= S_ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              count_q <= byte_in[ADDR_W:0];
              chk_q   <= byte_in;
              idx_q   <= '0;
              state_q <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (byte_accept) begin
            buf_q <= {buf_q[DATA_W-9:0], byte_in};
            chk_q <= chk_q ^ byte_in;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          // imem_we is high for exactly this one cycle.
          addr_q  <= addr_q + ADDR_ONE;
          words_q <= words_d;
          state_q <= (words_d == count_q) ? S_CHECK : S_COLLECT;
        end
        S_CHECK: begin
          if (byte_accept) begin
            busy_q <= 1'b0;
            if (byte_in == chk_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_we      = (state_q == S_WRITE);
  assign imem_addr    = addr_q;
  assign imem_wdata   = buf_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The pipeline fetch stage only reads instruction memory; this block fills it at run time.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words sequentially from address 0, validates the frame with an XOR checksum, and holds the CPU stalled while a load is in progress.

Parameters:
- ADDR_W, 5: instruction-memory address width (matches the PC width). Maximum word count is 2**ADDR_W.
- DATA_W, 32: instruction word width. Fixed at 4 bytes per word.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: one-cycle load request.
- byte_in, input, 8: stream byte.
- byte_valid, input, 1: byte_in is valid this cycle.
- byte_ready, output, 1: loader can accept a byte this cycle.
- imem_we, output, 1: instruction-memory write strobe.
- imem_addr, output, ADDR_W: write address.
- imem_wdata, output, DATA_W: assembled instruction word.
- cpu_hold, output, 1: stall/flush request to the fetch and decode stages.
- busy, output, 1: load in progress.
- done, output, 1: last load completed with a good checksum.
- error, output, 1: last load was rejected.
- words_loaded, output, ADDR_W+1: number of words written in the current or last load.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0, including byte_ready, imem_we, cpu_hold, done, error and words_loaded. Byte buffer, address and checksum registers are cleared.
- A byte is accepted only on a rising edge where byte_valid && byte_ready. Bytes presented with byte_ready low are not consumed; the source must hold them.
- Frame format: COUNT byte N, then N×4 data bytes (MSB first), then a CHK byte. CHK must equal the XOR of N and all data bytes.
- States:
  - IDLE / DONE / ERROR: byte_ready=0. start=1 → COUNT. On that edge: clear done, error, words_loaded, address and checksum; set busy=1 and cpu_hold=1.
  - COUNT: byte_ready=1. On accept, if N==0 or N>2**ADDR_W → ERROR. Otherwise store N, checksum=N, byte index=0 → COLLECT.
  - COLLECT: byte_ready=1. Each accepted byte shifts into the word buffer (buffer <= {buffer[23:0],byte}) and is XORed into the checksum; byte index increments. The 4th byte → WRITE.
  - WRITE: byte_ready=0. imem_we=1 for exactly one cycle, with imem_addr = current address and imem_wdata = assembled word. Next edge: address+1, words_loaded+1. If words_loaded+1==N → CHECK, else → COLLECT.
  - CHECK: byte_ready=1. On accept: byte==checksum → DONE (done=1, busy=0, cpu_hold=0); mismatch → ERROR (error=1, busy=0, cpu_hold stays 1).
- Throughput: 5 cycles per word minimum (4 accept cycles + 1 write cycle).
- cpu_hold rises on the edge that accepts start and stays high through ERROR. It clears only on entry to DONE, or on a new start that later completes.
- imem_addr wraps naturally. With N=2**ADDR_W the final write goes to address 2**ADDR_W−1. words_loaded reaches 2**ADDR_W without overflow because it is ADDR_W+1 bits wide.
- start while busy=1 is ignored. start in the same cycle as byte_valid in IDLE/DONE/ERROR: the byte is not consumed (byte_ready=0).
- Words already written before an ERROR remain in memory; there is no rollback.
- rst_n asserted mid-load: immediate return to IDLE and imem_we drops asynchronously. Partially assembled words are discarded.
- done and error are levels, held until the next accepted start or reset. They are never both 1.

Test Plan:
- Reset, then start, then stream 0x02, 0x01,0x23,0x45,0x67, 0x89,0xAB,0xCD,0xEF, CHK=0x02 → writes 0x01234567@0 and 0x89ABCDEF@1. Each imem_we is one cycle, 5 cycles after the previous one. done=1, cpu_hold=0, words_loaded=2.
- Same frame with CHK=0x03 → both words are written, then error=1, done=0, cpu_hold=1, busy=0.
- COUNT byte 0x00 → error on the next edge, no imem_we. COUNT byte 0x21 (ADDR_W=5) → error, no writes.
- N=0x20 with 128 data bytes and the correct CHK → 32 writes at addresses 0..31, words_loaded=32 (0b100000), done=1.
- Drive byte_valid with gaps (1 idle cycle between bytes) and byte_valid high during WRITE cycles → no byte is lost or duplicated; memory contents match the no-gap case.
- Pulse rst_n low after the 2nd data byte of word 0 → outputs go to 0 immediately. A fresh start then loads correctly from address 0, and start pulses while busy do not restart the frame.
